// File: rtl/scan_receiver.sv
// Scanner link receiver: syncs linkClk/linkData, deserializes MSB-first bytes, decodes commands and the data byte after code 7.
// Byte outputs update one cycle after the 8th detected rise; no backpressure, an unread data byte is kept and later ones set overrun.
module scan_receiver #(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       linkClk,
    input  logic       linkData,
    input  logic       dataRead,
    output logic       cmdValid,
    output logic [7:0] cmdCode,
    output logic       cmdError,
    output logic       dataValid,
    output logic [7:0] dataByte,
    output logic       frameError,
    output logic       overrun,
    output logic       scanActive
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);
    localparam logic [7:0] CODE_START  = 8'd3;
    localparam logic [7:0] CODE_STOP   = 8'd4;
    localparam logic [7:0] CODE_DATA   = 8'd7;

    state_t      state;
    state_t      stateNext;

    logic [1:0]  clkSync;
    logic [1:0]  dataSync;
    logic        clkPrev;
    logic        rise;
    logic        bitIn;

    logic [6:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic [7:0]  idleCnt;
    logic [7:0]  byteNow;
    logic        byteDone;
    logic        counting;
    logic        timeoutHit;

    logic        cmdDone;
    logic        dataDone;
    logic        codeLegal;
    logic        loadData;
    logic        dropData;
    logic        setScan;
    logic        clrScan;
    logic        readAck;

    assign rise     = clkSync[1] & ~clkPrev;
    assign bitIn    = dataSync[1];
    // Byte as it will stand once the current bit is shifted in.
    assign byteNow  = {shiftReg, bitIn};
    assign byteDone = rise && (state != IDLE) && (bitCnt == 3'd7);

    // Only a partially received frame can time out; DATA waiting for its first bit never does.
    assign counting   = (state != IDLE) && (bitCnt != 3'd0) && !rise;
    assign timeoutHit = counting && (idleCnt == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        if (timeoutHit) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) stateNext = CMD;
                CMD:     if (byteDone) stateNext = (byteNow == CODE_DATA) ? DATA : IDLE;
                DATA:    if (byteDone) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        cmdDone   = (state == CMD) && byteDone;
        dataDone  = (state == DATA) && byteDone;
        codeLegal = byteNow inside {8'd2, 8'd3, 8'd4, 8'd7};
        loadData  = dataDone && (!dataValid || dataRead);
        dropData  = dataDone && !loadData;
        setScan   = cmdDone && (byteNow == CODE_START);
        clrScan   = (cmdDone && (byteNow == CODE_STOP)) || dataDone;
        readAck   = dataRead && dataValid && !loadData;
    end

    // Synchronizers, edge detect, shift register and idle timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync  <= 2'b00;
            dataSync <= 2'b00;
            clkPrev  <= 1'b0;
            shiftReg <= 7'd0;
            bitCnt   <= 3'd0;
            idleCnt  <= 8'd0;
        end else begin
            clkSync  <= {clkSync[0], linkClk};
            dataSync <= {dataSync[0], linkData};
            clkPrev  <= clkSync[1];

            if (timeoutHit) begin
                bitCnt <= 3'd0;
            end else if (rise) begin
                shiftReg <= byteNow[6:0];
                bitCnt   <= bitCnt + 3'd1;
            end

            if (rise || timeoutHit) begin
                idleCnt <= 8'd0;
            end else if (counting) begin
                idleCnt <= idleCnt + 8'd1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdValid   <= 1'b0;
            cmdCode    <= 8'd0;
            cmdError   <= 1'b0;
            dataValid  <= 1'b0;
            dataByte   <= 8'd0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
            scanActive <= 1'b0;
        end else begin
            cmdValid   <= cmdDone;
            cmdError   <= cmdDone && !codeLegal;
            frameError <= timeoutHit;

            if (cmdDone) begin
                cmdCode <= byteNow;
            end

            if (loadData) begin
                dataByte  <= byteNow;
                dataValid <= 1'b1;
            end else if (readAck) begin
                dataValid <= 1'b0;
            end

            if (dropData) begin
                overrun <= 1'b1;
            end

            if (setScan) begin
                scanActive <= 1'b1;
            end else if (clrScan) begin
                scanActive <= 1'b0;
            end
        end
    end

endmodule
